serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised bit-serial adder/subtractor: adds two WIDTH-bit operands LSB-first, one bit per clock, through a single full-adder cell and a registered carry. It is the area-minimal successor to the combinational full adder. It adds a start/busy/done handshake, subtract mode, carry/borrow chaining and signed overflow. It sits beside datapath blocks that can trade latency for gate count.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request. Sampled only in IDLE.
- a  in  WIDTH  operand A. Sampled when start is accepted.
- b  in  WIDTH  operand B. Sampled when start is accepted.
- cin  in  1  carry-in (borrow-in when sub=1). Sampled with operands.
- sub  in  1  0 = A+B+cin; 1 = A−B−cin. Sampled with operands.
- busy  out  1  high while state ≠ IDLE.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result. Holds its value until the next DONE.
- cout  out  1  carry out of the MSB. In sub mode it is the inverted borrow: 1 = no borrow.
- overflow  out  1  signed two's-complement overflow of the last result.

## Operation
- States are IDLE, RUN and DONE.
- IDLE → RUN when start=1 at an edge.
  - Latch a into shift register ra.
  - Latch b ^ {WIDTH{sub}} into shift register rb.
  - Set carry ← cin ^ sub and bit counter ← 0.
- RUN, every edge:
  - s = ra[0]^rb[0]^carry.
  - carry ← (ra[0]&rb[0]) | ((ra[0]^rb[0])&carry).
  - ra and rb shift right. s shifts into the MSB of the internal result register.
  - counter increments.
  - On the edge where counter = WIDTH−1, also record carry-into-MSB (the carry value before that update). The state then goes RUN → DONE.
- At the RUN → DONE edge, the outputs load:
  - sum ← completed result register.
  - cout ← final carry.
  - overflow ← carry-into-MSB ^ final carry.
  - done ← 1.
- DONE → IDLE unconditionally on the next edge; done ← 0 there.
- start is ignored in RUN and in DONE. It is not queued.
- Operand inputs are don't-care except at the accepting edge.
- During RUN, sum, cout and overflow keep the previous result. They never expose partial values.
- Arithmetic is modulo 2^WIDTH.
- Counter width is $clog2(WIDTH). The counter never wraps within one operation.

## Timing
- Reset (rst_n=0 at an edge) takes priority over everything else. It:
  - sets state IDLE, busy 0, done 0;
  - sets sum 0, cout 0, overflow 0;
  - clears carry, counter and all shift registers.
- Reset mid-RUN aborts the operation and discards partial results.
- Start accepted at edge k:
  - busy=1 after edge k;
  - bits 0..WIDTH−1 are processed at edges k+1..k+WIDTH;
  - done=1 and new sum are valid after edge k+WIDTH;
  - busy=0 and done=0 after edge k+WIDTH+1.
- Latency is WIDTH cycles from acceptance to done.
- Throughput is one operation per WIDTH+2 cycles. The earliest next acceptance is edge k+WIDTH+2, when IDLE is sampled.
- Start held high continuously gives back-to-back operations every WIDTH+2 cycles.
- start asserted in the same cycle rst_n is released (rst_n=1): it is accepted at that edge if the state is IDLE.

## Structure
- Sub-module full_adder_cell: combinational; inputs a, b, cin; outputs s, cout. The only arithmetic in the block, instantiated once.
- Shared package serial_arith_pkg holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a localparam function for counter width.
- WIDTH bounds are checked by an elaboration-time assertion in serial_adder.

## Test plan
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, sub=0 → done exactly 8 cycles after acceptance; sum=8'h10, cout=0, overflow=0.
- WIDTH=8, a=8'h7F, b=8'h01, sub=0 → sum=8'h80, cout=0, overflow=1. Then a=8'hFF, b=8'h01, cin=1 → sum=8'h01, cout=1, overflow=0.
- WIDTH=8, sub=1, a=8'h05, b=8'h07, cin=0 → sum=8'hFE, cout=0 (borrow), overflow=0. Then a=8'h80, b=8'h01 → sum=8'h7F, overflow=1.
- Start pulsed during RUN and during DONE → ignored: exactly one done pulse. sum holds the old value until that done.
- rst_n=0 for one cycle at bit 4 of a run → busy=0, sum=0, no done pulse. The next start completes correctly.
- WIDTH=4, exhaustive over a, b, cin and sub (1024 operations), with start held high → every result matches the reference model. Operations are spaced exactly 6 cycles apart.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
// Holds the controller state encoding and the bit-counter width helper.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter must index bits 0..width-1; never narrower than one bit.
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder; the only arithmetic cell of the serial adder.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | ((a ^ b) & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: LSB-first, one bit per clock through one
// full-adder cell, with start/busy/done handshake and signed overflow.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; operands latched on the accepting edge
//   RUN   | one bit per edge, WIDTH edges; outputs hold previous result
//   DONE  | result registers loaded, done high for this single cycle
module serial_adder
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
      $error("serial_adder: WIDTH must be within 2..64");
   end

   state_e           state_q;
   logic [WIDTH-1:0] ra_q;
   logic [WIDTH-1:0] rb_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] res_d;
   logic             carry_q;
   logic             carry_d;
   logic             fa_s;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   full_adder_cell u_fa (
      .a    (ra_q[0]),
      .b    (rb_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (carry_d)
   );

   assign res_d = {fa_s, res_q[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  // Subtraction as A + ~B + 1, with the borrow-in folded into the +1.
                  ra_q    <= a;
                  rb_q    <= b ^ {WIDTH{sub}};
                  carry_q <= cin ^ sub;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               ra_q    <= {1'b0, ra_q[WIDTH-1:1]};
               rb_q    <= {1'b0, rb_q[WIDTH-1:1]};
               res_q   <= res_d;
               carry_q <= carry_d;
               if (cnt_q == LAST) begin
                  // carry_q is still the carry into the MSB on this edge.
                  sum_q   <= res_d;
                  cout_q  <= carry_d;
                  ovf_q   <= carry_q ^ carry_d;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 vector table and corner
// sequences, plus an exhaustive WIDTH=4 run with start held high.
module tb_serial_adder;

   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
      int         acc;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sub;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   logic       clk;
   logic       rst8, start8, cin8, sub8, busy8, done8, cout8, ovf8;
   logic [7:0] a8, b8, sum8;
   logic       rst4, start4, cin4, sub4, busy4, done4, cout4, ovf4;
   logic [3:0] a4, b4, sum4;

   exp_t       q8[$];
   exp_t       q4[$];
   vec_t       tbl[10];
   int         n_cmp = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         ndone8 = 0;
   int         ndone4 = 0;
   logic [7:0] last_sum8 = 8'h00;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .sub(sub8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
      .overflow(ovf8)
   );

   serial_adder #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst4), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .sub(sub4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
      .overflow(ovf4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Independent integer reference for the WIDTH=4 sweep.
   function automatic exp_t model4(input int n, input int acc);
      exp_t e;
      int av, bv, c, sa, sb, t, st;
      bv = n & 15;
      av = (n >> 4) & 15;
      c  = (n >> 8) & 1;
      sa = (av >= 8) ? av - 16 : av;
      sb = (bv >= 8) ? bv - 16 : bv;
      if (((n >> 9) & 1) == 1) begin
         t  = av - bv - c;
         st = sa - sb - c;
         e.cout = (t >= 0);
      end else begin
         t  = av + bv + c;
         st = sa + sb + c;
         e.cout = (t > 15);
      end
      e.sum = 8'(t & 15);
      e.ovf = (st > 7) || (st < -8);
      e.acc = acc;
      return e;
   endfunction

   task automatic drive4(input int n);
      b4   = 4'(n);
      a4   = 4'(n >> 4);
      cin4 = 1'(n >> 8);
      sub4 = 1'(n >> 9);
   endtask

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (done8 === 1'b1) begin
         ndone8++;
         if (q8.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done8: actual=done with sum %0h required=no done", sum8);
         end else begin
            e = q8.pop_front();
            chk("sum8", 64'(sum8), 64'(e.sum));
            chk("cout8", 64'(cout8), 64'(e.cout));
            chk("ovf8", 64'(ovf8), 64'(e.ovf));
            chk("latency8", 64'(cyc - e.acc), 64'(8));
         end
      end
   end

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (done4 === 1'b1) begin
         ndone4++;
         if (q4.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done4: actual=done with sum %0h required=no done", sum4);
         end else begin
            e = q4.pop_front();
            chk("sum4", 64'(sum4), 64'(e.sum[3:0]));
            chk("cout4", 64'(cout4), 64'(e.cout));
            chk("ovf4", 64'(ovf4), 64'(e.ovf));
            chk("latency4", 64'(cyc - e.acc), 64'(4));
         end
      end
   end

   task automatic wait_done8(input string tag);
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (done8 === 1'b1) got = 1;
         else chk({tag, "_hold"}, 64'(sum8), 64'(last_sum8));
      end
      if (!got) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s_timeout: actual=no done in 20 cycles required=done", tag);
      end
   endtask

   task automatic accept8(input vec_t v);
      exp_t e;
      @(negedge clk);
      a8 = v.a; b8 = v.b; cin8 = v.cin; sub8 = v.sub; start8 = 1'b1;
      @(posedge clk);
      #1;
      e.sum = v.sum; e.cout = v.cout; e.ovf = v.ovf; e.acc = cyc;
      q8.push_back(e);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      cin8 = 1'($urandom_range(0, 1)); sub8 = 1'($urandom_range(0, 1));
   endtask

   task automatic run8(input vec_t v, input string tag);
      accept8(v);
      chk({tag, "_busy"}, 64'(busy8), 64'(1));
      wait_done8(tag);
      last_sum8 = v.sum;
      @(negedge clk);
      chk({tag, "_done_low"}, 64'(done8), 64'(0));
      chk({tag, "_busy_low"}, 64'(busy8), 64'(0));
   endtask

   initial begin
      vec_t v;
      int   d0;
      tbl[0] = '{a:8'h0F, b:8'h01, cin:1'b0, sub:1'b0, sum:8'h10, cout:1'b0, ovf:1'b0};
      tbl[1] = '{a:8'h7F, b:8'h01, cin:1'b0, sub:1'b0, sum:8'h80, cout:1'b0, ovf:1'b1};
      tbl[2] = '{a:8'hFF, b:8'h01, cin:1'b1, sub:1'b0, sum:8'h01, cout:1'b1, ovf:1'b0};
      tbl[3] = '{a:8'h05, b:8'h07, cin:1'b0, sub:1'b1, sum:8'hFE, cout:1'b0, ovf:1'b0};
      tbl[4] = '{a:8'h80, b:8'h01, cin:1'b0, sub:1'b1, sum:8'h7F, cout:1'b1, ovf:1'b1};
      tbl[5] = '{a:8'h00, b:8'h00, cin:1'b0, sub:1'b0, sum:8'h00, cout:1'b0, ovf:1'b0};
      tbl[6] = '{a:8'hFF, b:8'hFF, cin:1'b1, sub:1'b0, sum:8'hFF, cout:1'b1, ovf:1'b0};
      tbl[7] = '{a:8'h00, b:8'h00, cin:1'b1, sub:1'b1, sum:8'hFF, cout:1'b0, ovf:1'b0};
      tbl[8] = '{a:8'h80, b:8'h80, cin:1'b0, sub:1'b0, sum:8'h00, cout:1'b1, ovf:1'b1};
      tbl[9] = '{a:8'h7F, b:8'hFF, cin:1'b0, sub:1'b1, sum:8'h80, cout:1'b0, ovf:1'b1};

      rst8 = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
      rst4 = 1'b0; start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy8", 64'(busy8), 64'(0));
      chk("rst_done8", 64'(done8), 64'(0));
      chk("rst_sum8", 64'(sum8), 64'(0));
      chk("rst_cout8", 64'(cout8), 64'(0));
      chk("rst_ovf8", 64'(ovf8), 64'(0));
      chk("rst_busy4", 64'(busy4), 64'(0));
      chk("rst_sum4", 64'(sum4), 64'(0));

      // Exhaustive WIDTH=4 sweep; start rises with reset release and stays high.
      drive4(0);
      start4 = 1'b1;
      rst4   = 1'b1;
      for (int n = 0; n < 1024; n++) begin
         @(posedge clk);
         #1;
         q4.push_back(model4(n, cyc));
         if (n < 1023) begin
            drive4(n + 1);
            repeat (5) @(posedge clk);
         end
      end
      start4 = 1'b0;
      repeat (12) @(negedge clk);
      chk("sweep4_count", 64'(ndone4), 64'(1024));
      chk("sweep4_pending", 64'(q4.size()), 64'(0));

      @(negedge clk);
      rst8 = 1'b1;
      for (int i = 0; i < 10; i++) run8(tbl[i], $sformatf("vec%0d", i));

      // start pulsed during RUN and during DONE must be ignored.
      v  = '{a:8'h12, b:8'h34, cin:1'b0, sub:1'b0, sum:8'h46, cout:1'b0, ovf:1'b0};
      d0 = ndone8;
      accept8(v);
      repeat (2) @(negedge clk);
      a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
      repeat (2) @(negedge clk);
      start8 = 1'b0;
      wait_done8("ignore");
      last_sum8 = v.sum;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      chk("ignore_done_low", 64'(done8), 64'(0));
      chk("ignore_busy_low", 64'(busy8), 64'(0));
      repeat (20) @(negedge clk);
      chk("ignore_one_done", 64'(ndone8 - d0), 64'(1));
      chk("ignore_busy_idle", 64'(busy8), 64'(0));
      chk("ignore_sum_kept", 64'(sum8), 64'(8'h46));

      // One-cycle reset landing on bit 4 aborts the run.
      d0 = ndone8;
      @(negedge clk);
      a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst8 = 1'b0;
      @(negedge clk);
      rst8 = 1'b1;
      chk("abort_busy", 64'(busy8), 64'(0));
      chk("abort_done", 64'(done8), 64'(0));
      chk("abort_sum", 64'(sum8), 64'(0));
      chk("abort_cout", 64'(cout8), 64'(0));
      chk("abort_ovf", 64'(ovf8), 64'(0));
      last_sum8 = 8'h00;
      repeat (20) @(negedge clk);
      chk("abort_no_done", 64'(ndone8 - d0), 64'(0));
      run8(tbl[1], "after_abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
